// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - CPU-side request/response bus for the data memory controller
interface data_memory_ctrl_if;
  logic       read;
  logic       write;
  logic [7:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - 256x8 data memory with fixed-latency busywait handshake
module data_memory_ctrl #(
  parameter int LATENCY = 5
) (
  input logic               clk,
  input logic               reset,
  data_memory_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // The accept cycle in IDLE counts as the first stall cycle, so BUSY runs LATENCY-1 cycles.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       op_wr_q, op_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] mem_q [256];
  logic       mem_we;
  logic       busy;
  logic       req_ok;

  assign req_ok = bus.read ^ bus.write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          busy    = 1'b1;
          state_d = BUSY;
          op_wr_d = bus.write;
          addr_d  = bus.address;
          wdata_d = bus.writedata;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          mem_we  = op_wr_q;
          if (!op_wr_q) begin
            rdata_d = mem_q[addr_q];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busywait = busy & ~reset;
  assign bus.readdata = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      for (int i = 0; i < 256; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      if (mem_we) begin
        mem_q[addr_q] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed vector bench for data_memory_ctrl
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  data_memory_ctrl_if bus1 ();
  data_memory_ctrl_if bus2 ();

  data_memory_ctrl #(.LATENCY(5)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  data_memory_ctrl #(.LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    string      name;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         exp_busy;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
    if (sel == 1) begin
      bus1.read = rd; bus1.write = wr; bus1.address = a; bus1.writedata = d;
    end else begin
      bus2.read = rd; bus2.write = wr; bus2.address = a; bus2.writedata = d;
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? bus1.busywait : bus2.busywait;
  endfunction

  function automatic logic [7:0] get_rdata(input int sel);
    return (sel == 1) ? bus1.readdata : bus2.readdata;
  endfunction

  // Counts stall cycles from the current sample point; ends in the DONE cycle.
  task automatic run(input int sel, output int cnt);
    cnt = 0;
    while (get_busy(sel) && cnt < 40) begin
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d,
                        output int cnt, output logic [7:0] rdata);
    drive(sel, rd, wr, a, d);
    #1;
    run(sel, cnt);
    rdata = get_rdata(sel);
    drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt;
    logic [7:0] rdata;

    vecs[0]  = '{"rd_10_zero",   1'b1, 1'b0, 8'h10, 8'h00, 5, 8'h00};
    vecs[1]  = '{"wr_3c_a5",     1'b0, 1'b1, 8'h3C, 8'hA5, 5, 8'h00};
    vecs[2]  = '{"rd_3c_a5",     1'b1, 1'b0, 8'h3C, 8'h00, 5, 8'hA5};
    vecs[3]  = '{"wr_80_5f",     1'b0, 1'b1, 8'h80, 8'h5F, 5, 8'hA5};
    vecs[4]  = '{"both_illegal", 1'b1, 1'b1, 8'h3C, 8'hFF, 0, 8'hA5};
    vecs[5]  = '{"rd_3c_kept",   1'b1, 1'b0, 8'h3C, 8'h00, 5, 8'hA5};
    vecs[6]  = '{"rd_80_5f",     1'b1, 1'b0, 8'h80, 8'h00, 5, 8'h5F};
    vecs[7]  = '{"no_request",   1'b0, 1'b0, 8'h44, 8'h99, 0, 8'h5F};
    vecs[8]  = '{"wr_ff_c3",     1'b0, 1'b1, 8'hFF, 8'hC3, 5, 8'h5F};
    vecs[9]  = '{"rd_ff_c3",     1'b1, 1'b0, 8'hFF, 8'h00, 5, 8'hC3};
    vecs[10] = '{"rd_00_zero",   1'b1, 1'b0, 8'h00, 8'h00, 5, 8'h00};

    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;

    // Request held through reset: stall suppressed, then accepted on release.
    drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
    #1;
    check("busy_forced_low_in_reset", int'(bus1.busywait), 0);
    @(posedge clk);
    #1;
    check("reset_readdata", int'(bus1.readdata), 8'h00);
    reset = 1'b0;
    #1;
    run(1, cnt);
    check("held_req_after_reset_busy", cnt, 5);
    check("held_req_after_reset_rdata", int'(bus1.readdata), 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      access(1, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, cnt, rdata);
      check({vecs[i].name, "_busy"}, cnt, vecs[i].exp_busy);
      check({vecs[i].name, "_rdata"}, int'(rdata), int'(vecs[i].exp_rdata));
    end

    // Inputs changed mid-access must not affect the latched write.
    drive(1, 1'b0, 1'b1, 8'h01, 8'h11);
    #1;
    @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b1, 8'h02, 8'h22);
    run(1, cnt);
    check("latched_wr_busy_tail", cnt, 4);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    access(1, 1'b1, 1'b0, 8'h01, 8'h00, cnt, rdata);
    check("latched_wr_data", int'(rdata), 8'h11);
    access(1, 1'b1, 1'b0, 8'h02, 8'h00, cnt, rdata);
    check("latched_wr_addr_untouched", int'(rdata), 8'h00);

    // Reset in the third stall cycle aborts the write.
    drive(1, 1'b0, 1'b1, 8'h20, 8'h77);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("busy_low_on_reset_mid_busy", int'(bus1.busywait), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    access(1, 1'b1, 1'b0, 8'h20, 8'h00, cnt, rdata);
    check("aborted_wr_busy", cnt, 5);
    check("aborted_wr_not_landed", int'(rdata), 8'h00);
    access(1, 1'b1, 1'b0, 8'hFF, 8'h00, cnt, rdata);
    check("reset_cleared_mem", int'(rdata), 8'h00);

    // LATENCY=2 instance: preload, then back-to-back reads.
    access(2, 1'b0, 1'b1, 8'h05, 8'h5A, cnt, rdata);
    check("l2_wr05_busy", cnt, 2);
    access(2, 1'b0, 1'b1, 8'h06, 8'h6B, cnt, rdata);
    check("l2_wr06_busy", cnt, 2);
    drive(2, 1'b1, 1'b0, 8'h05, 8'h00);
    #1;
    run(2, cnt);
    check("l2_rd05_busy", cnt, 2);
    check("l2_rd05_rdata", int'(bus2.readdata), 8'h5A);
    drive(2, 1'b1, 1'b0, 8'h06, 8'h00);
    @(posedge clk);
    #1;
    check("l2_no_gap_accept", int'(bus2.busywait), 1);
    run(2, cnt);
    check("l2_rd06_busy", cnt, 2);
    check("l2_rd06_rdata", int'(bus2.readdata), 8'h6B);
    drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check("l2_rdata_holds", int'(bus2.readdata), 8'h6B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter LATENCY, default 5: number of cycles BUSYWAIT stays high per accepted access; legal range 2..15.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 READ  input  1  read request from CPU, held high until BUSYWAIT sampled low.
REQ-005 WRITE  input  1  write request from CPU, held high until BUSYWAIT sampled low.
REQ-006 ADDRESS  input  8  byte address, held stable with the request.
REQ-007 WRITEDATA  input  8  write data, held stable with WRITE.
REQ-008 READDATA  output  8  registered read data, valid from the DONE cycle onward.
REQ-009 BUSYWAIT  output  1  stall to CPU; high while an access is pending.

Function
REQ-010 Storage: 256 x 8-bit array, indexed by ADDRESS.
REQ-011 FSM states IDLE, BUSY, DONE; 4-bit down-counter CNT.
REQ-012 IDLE: exactly one of READ/WRITE high -> BUSYWAIT=1 combinationally in the same cycle; at next edge latch op, ADDRESS, WRITEDATA, load CNT=LATENCY-2, go BUSY.
REQ-013 IDLE: READ and WRITE both high -> illegal request; no access, BUSYWAIT=0, stay IDLE.
REQ-014 IDLE: no request -> BUSYWAIT=0, stay IDLE.
REQ-015 BUSY: BUSYWAIT=1; CNT!=0 -> CNT decrements; CNT==0 -> at that edge perform the access with latched values and go DONE.
REQ-016 Total BUSYWAIT-high cycles per access = LATENCY (1 IDLE cycle + LATENCY-1 BUSY cycles).
REQ-017 Write access: mem[latched addr] <= latched WRITEDATA at the BUSY->DONE edge; READDATA unchanged.
REQ-018 Read access: READDATA <= mem[latched addr] at the BUSY->DONE edge.
REQ-019 DONE: BUSYWAIT=0 for exactly one cycle; request inputs ignored; next edge go IDLE unconditionally.
REQ-020 Request changes (ADDRESS/WRITEDATA/op) during BUSY have no effect; latched values are used.
REQ-021 READDATA holds its value until the next completed read or reset.
REQ-022 Back-to-back: a new request presented in the first IDLE cycle after DONE is accepted per REQ-012 (no extra dead cycle).
REQ-023 BUSYWAIT is forced to 0 in any cycle where RESET=1.

Reset
REQ-024 RESET=1 at a rising edge -> state IDLE, CNT=0, READDATA=8'h00, all 256 locations=8'h00.
REQ-025 RESET during BUSY -> access aborted; pending write never lands; pending read does not update READDATA.
REQ-026 RESET has priority over every other input in the same cycle.
REQ-027 Requests held high across reset release are accepted in the first cycle with RESET=0 per REQ-012.

Verification
REQ-028 Reset, then READ addr 8'h10 -> BUSYWAIT high 5 cycles, DONE cycle BUSYWAIT=0, READDATA=8'h00.
REQ-029 WRITE 8'hA5 to 8'h3C, then READ 8'h3C -> each BUSYWAIT high 5 cycles; READDATA=8'hA5 in the read's DONE cycle.
REQ-030 WRITE 8'h11 to 8'h01, change WRITEDATA to 8'h22 during BUSY -> later read of 8'h01 returns 8'h11.
REQ-031 WRITE 8'h77 to 8'h20, assert RESET in 3rd BUSYWAIT cycle -> BUSYWAIT=0 that cycle; later read of 8'h20 returns 8'h00.
REQ-032 READ and WRITE both high in IDLE -> BUSYWAIT stays 0, memory and READDATA unchanged.
REQ-033 LATENCY=2, back-to-back READs of 8'h05 then 8'h06 (preloaded 8'h5A, 8'h6B) -> each BUSYWAIT high 2 cycles, READDATA 8'h5A then 8'h6B, no idle gap between DONE and second accept.
